// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding load/store over valid/ready channels,
// fixed LATENCY, byte-lane placement for stores and sign/zero extension for loads.
// Optional feature macro DMEM_ERR_EN: when defined, illegal types and misaligned
// accesses are flagged on rsp_err; when undefined, low address bits are masked
// instead and rsp_err is tied low.
module dmem_responder #(
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_type,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned CntW = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e              state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic                wr_q;
    logic [ADDR_W+1:0]   addr_q;
    logic [31:0]         wdata_q;
    logic [2:0]          type_q;
    logic [31:0]         rsp_rdata_q;
    logic                rsp_err_q;

    logic [31:0]         mem [0:2**ADDR_W-1];

    logic                accept;
    logic                enter_resp;
    logic                cur_wr;
    logic [ADDR_W+1:0]   cur_addr;
    logic [31:0]         cur_wdata;
    logic [2:0]          cur_type;
    logic                is_b, is_h, is_w;
    logic [1:0]          lane;
    logic                err;
    logic [ADDR_W-1:0]   idx;
    logic [3:0]          be;
    logic [31:0]         wdata_lane;
    logic [31:0]         word;
    logic [7:0]          byte_sel;
    logic [15:0]         half_sel;
    logic [31:0]         load_data;

    // Upper address bits only alias the RAM; they are intentionally dropped.
    logic unused_addr;
    assign unused_addr = ^req_addr[31:ADDR_W+2];

    assign req_ready = (state_q == StIdle);
    assign rsp_valid = (state_q == StResp);
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign accept    = req_valid && (state_q == StIdle);

    // Next-state and wait-counter control.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        enter_resp = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    if (LATENCY == 1) begin
                        state_d    = StResp;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = StWait;
                        cnt_d   = CntW'(LATENCY - 2);
                    end
                end
            end
            StWait: begin
                if (cnt_q == '0) begin
                    state_d    = StResp;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StResp: begin
                if (rsp_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Decode the transaction being executed: live request when LATENCY == 1, else latched.
    always_comb begin
        cur_wr    = (state_q == StIdle) ? req_write : wr_q;
        cur_addr  = (state_q == StIdle) ? req_addr[ADDR_W+1:0] : addr_q;
        cur_wdata = (state_q == StIdle) ? req_wdata : wdata_q;
        cur_type  = (state_q == StIdle) ? req_type : type_q;

        is_b = (cur_type[1:0] == 2'b00);
        is_h = (cur_type[1:0] == 2'b01);
        is_w = cur_type[1];   // 010 plus the illegal 011/110/111 encodings
        lane = cur_addr[1:0];
        idx  = cur_addr[ADDR_W+1:2];

`ifdef DMEM_ERR_EN
        err = (cur_type == 3'b011) || (cur_type[2:1] == 2'b11)
            || (cur_wr && cur_type[2])
            || (is_h && cur_addr[0])
            || (is_w && (cur_addr[1:0] != 2'b00));
`else
        err = 1'b0;
        if (is_h) lane[0] = 1'b0;
        if (is_w) lane    = 2'b00;
`endif

        if (is_b) begin
            be         = 4'b0001 << lane;
            wdata_lane = {4{cur_wdata[7:0]}};
        end else if (is_h) begin
            be         = lane[1] ? 4'b1100 : 4'b0011;
            wdata_lane = {2{cur_wdata[15:0]}};
        end else begin
            be         = 4'b1111;
            wdata_lane = cur_wdata;
        end

        word     = mem[idx];
        byte_sel = 8'(word >> {lane, 3'b000});
        half_sel = lane[1] ? word[31:16] : word[15:0];
        if (is_b) begin
            load_data = cur_type[2] ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
        end else if (is_h) begin
            load_data = cur_type[2] ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
        end else begin
            load_data = word;
        end
    end

    // Control state, request capture and the registered response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            type_q      <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                wr_q    <= req_write;
                addr_q  <= req_addr[ADDR_W+1:0];
                wdata_q <= req_wdata;
                type_q  <= req_type;
            end
            if (enter_resp) begin
                rsp_rdata_q <= (cur_wr || err) ? 32'h0 : load_data;
                rsp_err_q   <= err;
            end
        end
    end

    // RAM write on the edge entering RESP; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (enter_resp && cur_wr && !err) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[idx][i*8 +: 8] <= wdata_lane[i*8 +: 8];
            end
        end
    end

endmodule
